// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives a 4-input combinational function through all
// 16 minterms, waits SETTLE_CYCLES per row, samples f_in, and compares the
// assembled truth table against EXPECTED.
// Optional feature: define TRUTH_TABLE_ERRCOUNT_EN to add the err_count output,
// which counts rows whose sample differs from EXPECTED.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'h0717
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  output logic [3:0]  abcd_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
`ifdef TRUTH_TABLE_ERRCOUNT_EN
  output logic [4:0]  err_count,
`endif
  output logic        pass
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Settle count at which the current row is sampled (legal 0..15).
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  logic [1:0]  state;
  logic [3:0]  row;
  logic [3:0]  settle;
  logic [15:0] table_next;
  logic        sample;

  // The row is sampled on the edge where the settle counter has reached its limit.
  assign sample = (state == DRIVE) && (settle == SETTLE_LAST);

  // Row index doubles as the stimulus; it wraps to 0 after row 15, so the
  // stimulus is back at 0 in DONE and IDLE without extra logic.
  assign abcd_out = row;
  assign busy     = (state == DRIVE);
  assign done     = (state == DONE);

  // Table as it will look after the current sample; pass is computed from
  // this so the row-15 bit is included on the final edge.
  always_comb begin
    // NOTE: default assignment first so no path leaves table_next unassigned (no latch).
    table_next      = table_out;
    table_next[row] = f_in;
  end

  // Sweep controller: IDLE -> DRIVE (16 rows) -> DONE (one cycle) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= 4'd0;
      settle    <= 4'd0;
      table_out <= 16'h0000;
      pass      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (state)
        IDLE: begin
          if (start) begin
            state     <= DRIVE;
            row       <= 4'd0;
            settle    <= 4'd0;
            table_out <= 16'h0000;
            pass      <= 1'b0;
          end
        end
        DRIVE: begin
          if (sample) begin
            table_out <= table_next;
            settle    <= 4'd0;
            row       <= row + 4'd1;
            if (row == 4'd15) begin
              state <= DONE;
              pass  <= (table_next == EXPECTED);
            end
          end else begin
            settle <= settle + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef TRUTH_TABLE_ERRCOUNT_EN
  // Count rows whose sampled value disagrees with the golden table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 5'd0;
    end else if ((state == IDLE) && start) begin
      err_count <= 5'd0;
    end else if (sample && (f_in != EXPECTED[row])) begin
      err_count <= err_count + 5'd1;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed bench for truth_table_sweeper. Three
// instances cover SETTLE_CYCLES = 2 (default), 0 and 1; f_in is produced by
// an independent model of f = b'd' + b'c' + a'c'd', stuck values, or the
// model delayed by two cycles.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [3];
  logic        f_in  [3];
  logic [3:0]  abcd  [3];
  logic        busy  [3];
  logic        done  [3];
  logic [15:0] tbl   [3];
  logic        pass_o[3];
`ifdef TRUTH_TABLE_ERRCOUNT_EN
  logic [4:0]  errc  [3];
`endif

  int n_checks = 0;
  int n_errors = 0;
  int mode0;          // instance 0 f_in source: 0 golden, 1 stuck-0, 2 delayed golden
  logic [1:0] dly0;
  logic [1:0] dly2;

  always #5 clk = ~clk;

  function automatic logic golden_f(input logic [3:0] x);
    logic a, b, c, d;
    {a, b, c, d} = x;
    return (~b & ~d) | (~b & ~c) | (~a & ~c & ~d);
  endfunction

  // Two-cycle delayed copies of the golden response for the settle tests.
  always @(posedge clk) begin
    dly0 <= {dly0[0], golden_f(abcd[0])};
    dly2 <= {dly2[0], golden_f(abcd[2])};
  end

  assign f_in[0] = (mode0 == 0) ? golden_f(abcd[0]) :
                   (mode0 == 1) ? 1'b0 : dly0[1];
  assign f_in[1] = 1'b1;
  assign f_in[2] = dly2[1];

  truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(16'h0717)) u_def (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .f_in(f_in[0]),
    .abcd_out(abcd[0]), .busy(busy[0]), .done(done[0]), .table_out(tbl[0]),
`ifdef TRUTH_TABLE_ERRCOUNT_EN
    .err_count(errc[0]),
`endif
    .pass(pass_o[0]));

  truth_table_sweeper #(.SETTLE_CYCLES(0), .EXPECTED(16'h0717)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .f_in(f_in[1]),
    .abcd_out(abcd[1]), .busy(busy[1]), .done(done[1]), .table_out(tbl[1]),
`ifdef TRUTH_TABLE_ERRCOUNT_EN
    .err_count(errc[1]),
`endif
    .pass(pass_o[1]));

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(16'h0717)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .f_in(f_in[2]),
    .abcd_out(abcd[2]), .busy(busy[2]), .done(done[2]), .table_out(tbl[2]),
`ifdef TRUTH_TABLE_ERRCOUNT_EN
    .err_count(errc[2]),
`endif
    .pass(pass_o[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle, then count cycles from the start edge until done.
  task automatic run_sweep(input int i, output int lat);
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
    check("busy_after_start", 32'(busy[i]), 32'd1);
    check("abcd_first_row", 32'(abcd[i]), 32'd0);
    lat = 0;
    while (done[i] !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int spurious;
    int wait_n;
    bit pulsed;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    mode0 = 0;
    #23;
    check("rst_abcd", 32'(abcd[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_table", 32'(tbl[0]), 32'd0);
    check("rst_pass", 32'(pass_o[0]), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of row 5.
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    wait_n = 0;
    while (abcd[0] !== 4'd5 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    check("reach_row5", 32'(abcd[0]), 32'd5);
    check("table_at_row5", 32'(tbl[0]), 32'h0017);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_abcd", 32'(abcd[0]), 32'd0);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_table", 32'(tbl[0]), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", 32'(busy[0]), 32'd0);

    // Golden function, default settle: 48-cycle latency, pass.
    run_sweep(0, lat);
    check("golden_latency", 32'(lat), 32'd48);
    check("golden_table", 32'(tbl[0]), 32'h0717);
    check("golden_pass", 32'(pass_o[0]), 32'd1);
    check("golden_busy_in_done", 32'(busy[0]), 32'd0);
    check("golden_abcd_in_done", 32'(abcd[0]), 32'd0);
`ifdef TRUTH_TABLE_ERRCOUNT_EN
    check("golden_errcount", 32'(errc[0]), 32'd0);
`endif
    @(negedge clk);
    check("done_one_cycle", 32'(done[0]), 32'd0);
    repeat (5) @(negedge clk);
    check("hold_table_idle", 32'(tbl[0]), 32'h0717);
    check("hold_pass_idle", 32'(pass_o[0]), 32'd1);

    // Start pulses at row 3 and in the DONE cycle are ignored.
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    lat = 0;
    pulsed = 1'b0;
    while (done[0] !== 1'b1 && lat < 400) begin
      if (abcd[0] == 4'd3 && !pulsed) begin
        start[0] = 1'b1;
        pulsed = 1'b1;
      end else begin
        start[0] = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start[0] = 1'b1;
    check("busy_restart_latency", 32'(lat), 32'd48);
    check("busy_restart_table", 32'(tbl[0]), 32'h0717);
    @(negedge clk) start[0] = 1'b0;
    check("done_start_ignored_busy", 32'(busy[0]), 32'd0);
    check("done_start_ignored_done", 32'(done[0]), 32'd0);
    spurious = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy[0] !== 1'b0 || done[0] !== 1'b0) spurious++;
    end
    check("no_queued_sweep", 32'(spurious), 32'd0);

    // Stuck-at-0 response.
    mode0 = 1;
    run_sweep(0, lat);
    check("stuck0_latency", 32'(lat), 32'd48);
    check("stuck0_table", 32'(tbl[0]), 32'h0000);
    check("stuck0_pass", 32'(pass_o[0]), 32'd0);
`ifdef TRUTH_TABLE_ERRCOUNT_EN
    check("stuck0_errcount", 32'(errc[0]), 32'd7);
`endif

    // Response delayed two cycles, settle 2: still captured correctly.
    mode0 = 2;
    repeat (3) @(negedge clk);
    run_sweep(0, lat);
    check("delay_s2_table", 32'(tbl[0]), 32'h0717);
    check("delay_s2_pass", 32'(pass_o[0]), 32'd1);

    // Stuck-at-1 with no settle: one row per cycle, 16-cycle latency.
    @(negedge clk) start[1] = 1'b1;
    @(negedge clk) start[1] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("s0_step_abcd", 32'(abcd[1]), 32'(k));
      @(negedge clk);
    end
    check("s0_done_at_16", 32'(done[1]), 32'd1);
    check("s0_table", 32'(tbl[1]), 32'hFFFF);
    check("s0_pass", 32'(pass_o[1]), 32'd0);
    check("s0_abcd_wrapped", 32'(abcd[1]), 32'd0);
`ifdef TRUTH_TABLE_ERRCOUNT_EN
    check("s0_errcount", 32'(errc[1]), 32'd9);
`endif

    // Response delayed two cycles, settle 1: each row catches the previous minterm.
    run_sweep(2, lat);
    check("delay_s1_latency", 32'(lat), 32'd32);
    check("delay_s1_table", 32'(tbl[2]), 32'h0E2F);
    check("delay_s1_pass", 32'(pass_o[2]), 32'd0);
`ifdef TRUTH_TABLE_ERRCOUNT_EN
    check("delay_s1_errcount", 32'(errc[2]), 32'd5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
